// File: rtl/decode_stage.sv
// decode_stage: fetch-to-execute pipeline register with field decode and a 2-entry skid buffer.
// Ports: clk/rst (sync, active-high), flush (drop buffered work),
//   in_valid/in_ready/in_instr/in_pc (fetch side),
//   out_valid/out_ready plus decoded out_pc/op/rd/rs1/rs2/imm/imm_src/use_imm/illegal (execute side),
//   dispatch_count (wrapping count of handed-off instructions).
// Optional macro ILLEGAL_TRAP_EN: reserved ops raise out_illegal and a sticky stall until flush/rst.
module decode_stage #(
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_instr,
  input  logic [PC_W-1:0]  in_pc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PC_W-1:0]  out_pc,
  output logic [3:0]       out_op,
  output logic [3:0]       out_rd,
  output logic [3:0]       out_rs1,
  output logic [3:0]       out_rs2,
  output logic [23:0]      out_imm,
  output logic [1:0]       out_imm_src,
  output logic             out_use_imm,
  output logic             out_illegal,
  output logic [CNT_W-1:0] dispatch_count
);
  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
    logic [1:0]      src;
    logic            use_imm;
    logic            ill;
  } entry_t;

  entry_t out_q, out_d, skid_q, skid_d, in_e;
  logic out_v_q, out_v_d, skid_v_q, skid_v_d, rdy_q, rdy_d, acc, drn;
  logic [CNT_W-1:0] cnt_q;
  logic [3:0] op;

  assign op = in_instr[31:28];

  always_comb begin
    in_e.pc = in_pc;
    in_e.instr = in_instr;
    in_e.src = op <= 4'd3 ? 2'd3 : op <= 4'd7 ? 2'd1 : op <= 4'd9 ? 2'd0 : op <= 4'd11 ? 2'd2 : 2'd3;
    in_e.use_imm = op >= 4'd4 && op <= 4'd11;
`ifdef ILLEGAL_TRAP_EN
    in_e.ill = op >= 4'd12 && op <= 4'd14;
`else
    in_e.ill = 1'b0;
`endif
  end

`ifdef ILLEGAL_TRAP_EN
  logic trap_q, trap_d;
  // Trap is sticky: once an illegal op is taken, fetch stalls until a flush redirects it.
  assign trap_d = !flush && (trap_q || (acc && in_e.ill));
  always_ff @(posedge clk)
    if (rst) trap_q <= 1'b0;
    else trap_q <= trap_d;
`endif

  always_comb begin
    acc = in_valid && rdy_q;
    drn = out_v_q && out_ready;
    out_v_d = out_v_q;
    skid_v_d = skid_v_q;
    out_d = out_q;
    skid_d = skid_q;
    if (flush) begin
      out_v_d = 1'b0;
      skid_v_d = 1'b0;
    end else if (!out_v_q || drn) begin
      // Output slot frees up: the older skid entry goes first to keep program order.
      out_v_d = skid_v_q || acc;
      out_d = skid_v_q ? skid_q : acc ? in_e : out_q;
      skid_v_d = skid_v_q && acc;
      skid_d = skid_v_q && acc ? in_e : skid_q;
    end else if (acc) begin
      skid_v_d = 1'b1;
      skid_d = in_e;
    end
`ifdef ILLEGAL_TRAP_EN
    rdy_d = !skid_v_d && !trap_d;
`else
    rdy_d = !skid_v_d;
`endif
  end

  always_ff @(posedge clk)
    if (rst) begin
      out_v_q <= 1'b0;
      skid_v_q <= 1'b0;
      out_q <= '0;
      skid_q <= '0;
      rdy_q <= 1'b1;
      cnt_q <= '0;
    end else begin
      out_v_q <= out_v_d;
      skid_v_q <= skid_v_d;
      out_q <= out_d;
      skid_q <= skid_d;
      rdy_q <= rdy_d;
      cnt_q <= cnt_q + CNT_W'(drn);
    end

  assign in_ready = rdy_q;
  assign out_valid = out_v_q;
  assign out_pc = out_q.pc;
  assign out_op = out_q.instr[31:28];
  assign out_rd = out_q.instr[27:24];
  assign out_rs1 = out_q.instr[23:20];
  assign out_rs2 = out_q.instr[19:16];
  assign out_imm = out_q.instr[23:0];
  assign out_imm_src = out_q.src;
  assign out_use_imm = out_q.use_imm;
  assign out_illegal = out_q.ill;
  assign dispatch_count = cnt_q;
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed and random checks of decode_stage against a FIFO-level reference model.
module tb_decode_stage;
  localparam int PC_W = 32;
  localparam int CNT_W = 4;
  logic clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
  logic [31:0] in_instr = 0;
  logic [PC_W-1:0] in_pc = 0;
  logic in_ready, out_valid, out_use_imm, out_illegal;
  logic [PC_W-1:0] out_pc;
  logic [3:0] out_op, out_rd, out_rs1, out_rs2;
  logic [23:0] out_imm;
  logic [1:0] out_imm_src;
  logic [CNT_W-1:0] dispatch_count;
  int pass_n = 0, tot_n = 0;
  bit started = 0;
  logic [31:0] q_instr[$];
  logic [31:0] q_pc[$];
  bit m_trap = 0, m_acc, m_drn;
  int m_cnt = 0;
  bit trap_en;

  decode_stage #(.PC_W(PC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_op(out_op), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_imm(out_imm), .out_imm_src(out_imm_src), .out_use_imm(out_use_imm),
    .out_illegal(out_illegal), .dispatch_count(dispatch_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tot_n++;
    if (act === exp) pass_n++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic logic [1:0] m_src(input logic [3:0] op);
    if (op inside {[4'd4:4'd7]}) return 2'd1;
    if (op inside {4'd8, 4'd9}) return 2'd0;
    if (op inside {4'd10, 4'd11}) return 2'd2;
    return 2'd3;
  endfunction

  function automatic logic m_ill(input logic [3:0] op);
    return trap_en && op inside {[4'd12:4'd14]};
  endfunction

  initial begin
`ifdef ILLEGAL_TRAP_EN
    trap_en = 1;
`else
    trap_en = 0;
`endif
  end

  always @(posedge clk) begin
    if (rst) begin
      q_instr.delete();
      q_pc.delete();
      m_trap = 0;
      m_cnt = 0;
    end else begin
      m_drn = q_instr.size() > 0 && out_ready;
      m_acc = in_valid && q_instr.size() < 2 && !m_trap;
      if (m_drn) m_cnt = (m_cnt + 1) % 16;
      if (flush) begin
        q_instr.delete();
        q_pc.delete();
        m_trap = 0;
      end else begin
        if (m_drn) begin
          void'(q_instr.pop_front());
          void'(q_pc.pop_front());
        end
        if (m_acc) begin
          q_instr.push_back(in_instr);
          q_pc.push_back(in_pc);
          if (m_ill(in_instr[31:28])) m_trap = 1;
        end
      end
    end
  end

  always @(negedge clk) if (started) begin
    chk("out_valid", out_valid, q_instr.size() > 0);
    chk("in_ready", in_ready, q_instr.size() < 2 && !m_trap);
    chk("dispatch_count", dispatch_count, m_cnt);
    if (q_instr.size() > 0) begin
      chk("out_pc", out_pc, q_pc[0]);
      chk("out_op", out_op, q_instr[0][31:28]);
      chk("out_rd", out_rd, q_instr[0][27:24]);
      chk("out_rs1", out_rs1, q_instr[0][23:20]);
      chk("out_rs2", out_rs2, q_instr[0][19:16]);
      chk("out_imm", out_imm, q_instr[0][23:0]);
      chk("out_imm_src", out_imm_src, m_src(q_instr[0][31:28]));
      chk("out_use_imm", out_use_imm, q_instr[0][31:28] inside {[4'd4:4'd11]});
      chk("out_illegal", out_illegal, m_ill(q_instr[0][31:28]));
    end
  end

  task automatic push1(input logic [31:0] ins, input logic [31:0] pc);
    in_valid = 1;
    in_instr = ins;
    in_pc = pc;
    @(negedge clk);
    in_valid = 0;
  endtask

  task automatic do_reset;
    rst = 1;
    flush = 0;
    in_valid = 0;
    out_ready = 0;
    @(negedge clk);
    rst = 0;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_count", dispatch_count, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_imm", out_imm, 0);
    chk("rst_fields", {out_op, out_rd, out_imm_src, out_use_imm, out_illegal}, 0);
  endtask

  initial begin
    @(negedge clk);
    @(negedge clk);
    started = 1;
    do_reset();
    // Single instruction with literal expectations.
    out_ready = 1;
    push1(32'h5A123456, 32'h100);
    chk("t1_valid", out_valid, 1);
    chk("t1_op", out_op, 4'h5);
    chk("t1_rd", out_rd, 4'hA);
    chk("t1_rs1", out_rs1, 4'h1);
    chk("t1_rs2", out_rs2, 4'h2);
    chk("t1_imm", out_imm, 24'h123456);
    chk("t1_src", out_imm_src, 2'd1);
    chk("t1_use", out_use_imm, 1);
    chk("t1_pc", out_pc, 32'h100);
    @(negedge clk);
    chk("t1_count", dispatch_count, 1);
    // Back-pressure: third instruction held until space frees.
    out_ready = 0;
    in_valid = 1;
    in_instr = 32'h80000011; in_pc = 32'h200;
    @(negedge clk);
    in_instr = 32'hA0000022; in_pc = 32'h204;
    @(negedge clk);
    chk("bp_ready_low", in_ready, 0);
    in_instr = 32'h00000033; in_pc = 32'h208;
    @(negedge clk);
    chk("bp_hold_src", out_imm_src, 2'd0);
    chk("bp_hold_ready", in_ready, 0);
    out_ready = 1;
    @(negedge clk);
    chk("bp_src2", out_imm_src, 2'd2);
    @(negedge clk);
    in_valid = 0;
    chk("bp_src3", out_imm_src, 2'd3);
    chk("bp_imm3", out_imm, 24'h000033);
    @(negedge clk);
    chk("bp_count", dispatch_count, 4);
    // Flush with both entries full and input pending.
    out_ready = 0;
    in_valid = 1;
    in_instr = 32'h40000001;
    @(negedge clk);
    in_instr = 32'h40000002;
    @(negedge clk);
    in_instr = 32'h40000003;
    flush = 1;
    @(negedge clk);
    flush = 0;
    in_valid = 0;
    chk("fl_valid", out_valid, 0);
    chk("fl_ready", in_ready, 1);
    chk("fl_count", dispatch_count, 4);
    out_ready = 1;
    push1(32'hF0000077, 32'h300);
    chk("fl_new_imm", out_imm, 24'h000077);
    @(negedge clk);
    chk("fl_alone", out_valid, 0);
    // Counter wrap.
    do_reset();
    out_ready = 1;
    for (int i = 0; i < 17; i++) begin
      push1(32'h10000000 + i, 32'h400 + 4 * i);
      @(negedge clk);
      if (i == 14) chk("wrap_15", dispatch_count, 15);
      if (i == 15) chk("wrap_0", dispatch_count, 0);
      if (i == 16) chk("wrap_1", dispatch_count, 1);
    end
    // Reset mid-stream with both entries full.
    out_ready = 0;
    push1(32'h90000001, 32'h500);
    push1(32'hB0000002, 32'h504);
    do_reset();
    // Reserved opcode handling.
    push1(32'hD0000000, 32'h600);
    chk("ill_src", out_imm_src, 2'd3);
    chk("ill_flag", out_illegal, trap_en);
    chk("ill_ready", in_ready, !trap_en);
    push1(32'h40000001, 32'h604);
    chk("ill_second", in_ready, 0);
    flush = 1;
    @(negedge clk);
    flush = 0;
    chk("ill_flush_ready", in_ready, 1);
    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      in_valid = $urandom_range(0, 3) != 0;
      in_instr = $urandom;
      in_pc = $urandom;
      out_ready = $urandom_range(0, 2) != 0;
      flush = $urandom_range(0, 15) == 0;
      rst = $urandom_range(0, 99) == 0;
      @(negedge clk);
    end
    rst = 0;
    flush = 0;
    in_valid = 0;
    @(negedge clk);
    $display("%0d/%0d checks passed", pass_n, tot_n);
    $finish;
  end
endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- Pipeline register and field decoder between instruction fetch and the immediate extend unit / register file.
- Accepts 32-bit instructions with a valid/ready handshake and splits them into op, register and immediate fields.
- Produces the 24-bit raw immediate plus the 2-bit imm_src selector that the extend unit consumes.
- Holds a 2-entry skid buffer, so back-pressure from execute never drops an instruction; supports flush on branch.

Parameters:
PC_W, 32, width of the program counter carried with each instruction
CNT_W, 16, width of the dispatched-instruction counter

Ports:
clk  input  1  clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
flush  input  1  discard all buffered instructions (branch taken)
in_valid  input  1  fetch presents an instruction
in_ready  output  1  stage can accept an instruction this cycle
in_instr  input  32  instruction word
in_pc  input  PC_W  PC of in_instr
out_valid  output  1  decoded instruction available
out_ready  input  1  downstream consumes the decoded instruction
out_pc  output  PC_W  PC of the decoded instruction
out_op  output  4  instr[31:28]
out_rd  output  4  instr[27:24]
out_rs1  output  4  instr[23:20]
out_rs2  output  4  instr[19:16]
out_imm  output  24  instr[23:0], raw, to the extend unit
out_imm_src  output  2  extend selector: 0 = 10-bit, 1 = 12-bit, 2 = 20-bit, 3 = none
out_use_imm  output  1  ALU operand B comes from the extended immediate
out_illegal  output  1  reserved opcode (macro only)
dispatch_count  output  CNT_W  instructions handed downstream

Behaviour:
- Clocking and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: out_valid = 0; all data outputs = 0; dispatch_count = 0; skid buffer empty; in_ready = 1 in the first cycle after reset.
- Opcode decode (combinational on the input, registered with the entry):
  - op 0x0-0x3: register ALU; imm_src = 3, use_imm = 0.
  - op 0x4-0x7: immediate ALU; imm_src = 1, use_imm = 1.
  - op 0x8-0x9: load/store; imm_src = 0, use_imm = 1.
  - op 0xA-0xB: branch; imm_src = 2, use_imm = 1.
  - op 0xC-0xE: reserved.
  - op 0xF: nop; imm_src = 3, use_imm = 0.
- Storage: output register (OR) plus skid register (SK). in_ready = !SK.valid, driven straight from a flop.
- Transfer: an input is accepted when in_valid && in_ready.
- Input latency: an accepted instruction appears on the out_* ports 1 cycle later if OR is empty or drains that cycle; otherwise it goes to SK.
- Fill and drain order:
  - When OR drains (out_valid && out_ready) and SK is valid, SK moves to OR in the same edge.
  - A simultaneous accept then lands in SK.
  - Program order is always preserved.
- Hold rule: while out_valid && !out_ready, all out_* fields are stable.
- Full buffer: with both entries full, in_ready = 0 and in_instr is ignored.
- Flush:
  - On the next edge both entries are invalidated and any input accepted that cycle is dropped.
  - Next cycle: out_valid = 0, in_ready = 1.
  - Flush has priority over every transfer; rst has priority over flush.
- dispatch_count:
  - Increments by 1 on each out_valid && out_ready edge, including when flush is high that cycle.
  - Wraps from 2^CNT_W-1 to 0.
  - Not cleared by flush.
- Reset mid-operation: buffered instructions are discarded and nothing is output.

Optional Feature:
Macro ILLEGAL_TRAP_EN.
- Defined:
  - A reserved op (0xC-0xE) is accepted and output with out_illegal = 1, imm_src = 3, use_imm = 0.
  - After that instruction is accepted, a sticky trap flag forces in_ready = 0 until flush or rst clears it.
  - Entries already buffered still drain normally.
- Undefined:
  - Reserved ops decode exactly as nop (imm_src = 3, use_imm = 0).
  - out_illegal is tied to 0 and there is no trap flag.

Test Plan:
- Single instruction: in_instr = 0x5A123456, in_pc = 0x100, out_ready = 1 -> next cycle out_valid = 1, out_op = 5, out_rd = 0xA, out_rs1 = 1, out_rs2 = 2, out_imm = 0x123456, out_imm_src = 1, out_use_imm = 1, out_pc = 0x100; dispatch_count = 1.
- Back-pressure: out_ready = 0, push 0x8..., 0xA..., 0x0... back-to-back -> in_ready drops after the 2nd accept; third held. Raise out_ready -> outputs in order with imm_src 0, 2, 3 and no loss.
- Flush with both entries full and in_valid = 1 -> next cycle out_valid = 0, in_ready = 1; dispatch_count unchanged; new instruction after flush emerges alone.
- Counter wrap: CNT_W = 4, stream 17 instructions with out_ready = 1 -> dispatch_count goes 15 -> 0 -> 1.
- Reset mid-stream: assert rst for 1 cycle with both entries full -> out_valid = 0, all outputs 0, dispatch_count = 0, in_ready = 1 the following cycle.
- ILLEGAL_TRAP_EN: push 0xD0000000 then 0x40000001 -> first output has out_illegal = 1, and in_ready = 0 after the 0xD0000000 accept so 0x40000001 is not taken; in_ready = 1 after flush. Without macro: 0xD0000000 outputs imm_src = 3, out_illegal = 0, and the stream continues.
